// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: field positions, NOP encoding,
// FSM state encoding and word-alignment helper.
package fetch_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned OP_LSB = 0;
    localparam int unsigned F3_LSB = 12;
    localparam int unsigned F7_LSB = 25;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential PC+4, taken branch/jump target, or flush redirect,
// with redirect targets forced to word alignment and misalignment flagged.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] pc_target,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] pc_plus4_c,
    output logic [XLEN-1:0] pc_next_c,
    output logic            misaligned_c
);

    logic [XLEN-1:0] target_c;
    logic            redirect_c;

    // flush outranks a taken branch
    always_comb begin
        pc_plus4_c   = pc + XLEN'(4);
        redirect_c   = flush || pcsrc;
        target_c     = flush ? flush_pc : pc_target;
        misaligned_c = redirect_c && (target_c[1:0] != 2'b00);
        pc_next_c    = redirect_c ? align_word(target_c) : pc_plus4_c;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request, instruction
// register and decoder field taps. Flushed in-flight responses are dropped via a kill flag.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [6:0]  Op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misaligned
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_c, pc_next_c;
    logic            misaligned_c;

    fetch_unit_pc_next u_pc_next (
        .pc           (pc_q),
        .pcsrc        (PCSrc),
        .pc_target    (PCTarget),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .pc_plus4_c   (pc_plus4_c),
        .pc_next_c    (pc_next_c),
        .misaligned_c (misaligned_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            pc_q    <= align_word(RESET_PC);
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        if (flush) begin
            pc_d    = pc_next_c;
            mis_d   = mis_q | misaligned_c;
            valid_d = 1'b0;
            instr_d = NOP;
            // a request issued in FETCH, or still pending in WAIT, must have its response dropped
            unique case (state_q)
                ST_FETCH: begin
                    state_d = ST_WAIT;
                    kill_d  = 1'b1;
                end
                ST_WAIT: begin
                    state_d = imem_rvalid ? ST_FETCH : ST_WAIT;
                    kill_d  = !imem_rvalid;
                end
                default: begin
                    state_d = ST_FETCH;
                    kill_d  = 1'b0;
                end
            endcase
        end else begin
            unique case (state_q)
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_FETCH;
                        end else begin
                            instr_d = imem_rdata;
                            valid_d = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_d    = pc_next_c;
                        mis_d   = mis_q | misaligned_c;
                        valid_d = 1'b0;
                        instr_d = NOP;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // request strobe is a pure decode of the state register, suppressed during reset
    assign imem_req   = (state_q == ST_FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4_c;
    assign misaligned = mis_q;
    assign Op         = instr_q[OP_LSB +: OP_W];
    assign funct3     = instr_q[F3_LSB +: F3_W];
    assign funct7     = instr_q[F7_LSB +: F7_W];

endmodule
